noc_conf_wb_slave: RTL and testbench

//  Wishbone B3 classic slave answering configuration accesses issued by the compute-tile

---
 rtl/noc_conf_wb_slave.sv | 144 ++++++++++++++
 tb/tb_noc_conf_wb_slave.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_conf_wb_slave.sv
// Wishbone B3 classic configuration slave: tile identity, scratch, IRQ status/mask, access counter.
// Optional free-running TIMESTAMP register at 0x1C is enabled by defining NOC_CONF_TIMESTAMP_EN.
module noc_conf_wb_slave #(
  parameter logic [31:0] TILEID   = 32'd0,
  parameter logic [31:0] NUMTILES = 32'd1,
  parameter logic [31:0] COREBASE = 32'd0,
  parameter int          IRQ_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  input  logic [IRQ_W-1:0] irq_src_i,
  output logic             irq_o,
  output logic             o_dbg_state
);

  // Handshake: a request (cyc & stb) seen in IDLE moves to RESP; in RESP exactly one of
  // ack/err is driven combinationally if the request is still held, and any write commits
  // on that clock edge. RESP always returns to IDLE, so terminations never occur back to back.
  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_scratch;
  logic [IRQ_W-1:0]  r_status;
  logic [IRQ_W-1:0]  r_mask;
  logic [31:0]       r_cnt;
  logic              r_irq;

  logic              w_req;
  logic              w_resp;
  logic              w_reject;
  logic              w_ack;
  logic              w_err;
  logic              w_wr;
  logic [2:0]        w_idx;
  logic [31:0]       w_lanes;
  logic [31:0]       w_wdat_masked;
  logic [31:0]       w_rdata;
  logic [IRQ_W-1:0]  w_clr;
  logic [IRQ_W-1:0]  w_status_nxt;
  logic [IRQ_W-1:0]  w_mask_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_req  = wb_cyc_i & wb_stb_i;
  assign w_resp = (r_state == S_RESP) & w_req;
  assign w_idx  = wb_adr_i[4:2];

  always_comb begin
    w_reject = (wb_adr_i[1:0] != 2'b00) || (wb_adr_i[31:5] != 27'd0);
    case (w_idx)
      3'd0, 3'd1, 3'd2, 3'd6: if (wb_we_i) w_reject = 1'b1;
`ifdef NOC_CONF_TIMESTAMP_EN
      3'd7: if (wb_we_i) w_reject = 1'b1;
`else
      3'd7: w_reject = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_ack         = w_resp & ~w_reject;
  assign w_err         = w_resp & w_reject;
  assign w_wr          = w_ack & wb_we_i;
  assign w_lanes       = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wdat_masked = wb_dat_i & w_lanes;

  // A coincident set pulse overrides a W1C on the same bit.
  assign w_clr        = (w_wr && w_idx == 3'd4) ? w_wdat_masked[IRQ_W-1:0] : '0;
  assign w_status_nxt = (r_status & ~w_clr) | irq_src_i;
  assign w_mask_nxt   = (w_wr && w_idx == 3'd5) ?
                        ((r_mask & ~w_lanes[IRQ_W-1:0]) | w_wdat_masked[IRQ_W-1:0]) : r_mask;

`ifdef NOC_CONF_TIMESTAMP_EN
  logic [31:0] r_ts;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ts <= 32'd0;
    else        r_ts <= r_ts + 32'd1;
  end
`endif

  always_comb begin
    w_rdata = 32'd0;
    if (w_ack) begin
      case (w_idx)
        3'd0: w_rdata = TILEID;
        3'd1: w_rdata = NUMTILES;
        3'd2: w_rdata = COREBASE;
        3'd3: w_rdata = r_scratch;
        3'd4: w_rdata[IRQ_W-1:0] = r_status;
        3'd5: w_rdata[IRQ_W-1:0] = r_mask;
        3'd6: w_rdata = r_cnt;
`ifdef NOC_CONF_TIMESTAMP_EN
        3'd7: w_rdata = r_ts;
`endif
        default: w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch <= 32'd0;
      r_status  <= '0;
      r_mask    <= '0;
      r_cnt     <= 32'd0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && w_idx == 3'd3) r_scratch <= (r_scratch & ~w_lanes) | w_wdat_masked;
      r_status <= w_status_nxt;
      r_mask   <= w_mask_nxt;
      if (w_ack) r_cnt <= r_cnt + 32'd1;
      r_irq <= |(w_status_nxt & w_mask_nxt);
    end
  end

  assign wb_dat_o    = w_rdata;
  assign wb_ack_o    = w_ack;
  assign wb_err_o    = w_err;
  assign irq_o       = r_irq;
  assign o_dbg_state = (r_state == S_RESP);

endmodule

// File: tb/tb_noc_conf_wb_slave.sv
// Self-checking bench for noc_conf_wb_slave: directed scenarios plus randomized accesses
// checked against a register-level reference model.
module tb_noc_conf_wb_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [1:0]  irq_src_i;
  logic        irq_o;
  logic        o_dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  logic [31:0] m_scratch;
  logic [31:0] m_cnt;
  logic [1:0]  m_status;
  logic [1:0]  m_mask;

  noc_conf_wb_slave #(
    .TILEID(32'd5), .NUMTILES(32'd4), .COREBASE(32'd20), .IRQ_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .irq_src_i(irq_src_i), .irq_o(irq_o), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_scratch = 32'd0;
    m_cnt     = 32'd0;
    m_status  = 2'b00;
    m_mask    = 2'b00;
  endfunction

  // Spec-level behaviour of one access; returns expected err and read data (pre-access values).
  task automatic model_op(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, input logic [1:0] src,
                          output logic e_err, output logic [31:0] e_rd);
    logic [31:0] bm;
    logic [1:0]  clr;
    bm    = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    clr   = 2'b00;
    e_err = 1'b0;
    e_rd  = 32'd0;
    if (adr % 4 != 0 || adr >= 32) e_err = 1'b1;
    else if (adr == 32'h00) begin e_rd = 32'd5;  e_err = we; end
    else if (adr == 32'h04) begin e_rd = 32'd4;  e_err = we; end
    else if (adr == 32'h08) begin e_rd = 32'd20; e_err = we; end
    else if (adr == 32'h0C) e_rd = m_scratch;
    else if (adr == 32'h10) e_rd = {30'd0, m_status};
    else if (adr == 32'h14) e_rd = {30'd0, m_mask};
    else if (adr == 32'h18) begin e_rd = m_cnt; e_err = we; end
    else begin
`ifdef NOC_CONF_TIMESTAMP_EN
      e_err = we;
`else
      e_err = 1'b1;
`endif
    end
    if (!e_err) begin
      if (we && adr == 32'h0C) m_scratch = (m_scratch & ~bm) | (dat & bm);
      if (we && adr == 32'h10) clr = dat[1:0] & bm[1:0];
      if (we && adr == 32'h14) m_mask = (m_mask & ~bm[1:0]) | (dat[1:0] & bm[1:0]);
      m_cnt = m_cnt + 32'd1;
    end
    m_status = (m_status & ~clr) | src;
  endtask

  // Driver: request in cycle N, sample termination in cycle N+1, release afterwards.
  task automatic do_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input logic [1:0] src_resp,
                           output logic ack, output logic err, output logic [31:0] rd,
                           output logic early);
    @(posedge clk); #1;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; irq_src_i = 2'b00;
    #1 early = wb_ack_o | wb_err_o;
    @(posedge clk); #1;
    irq_src_i = src_resp;
    ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; irq_src_i = 2'b00;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'd0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; irq_src_i = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic ack, err, early;
    logic [31:0] rd;
    apply_reset();
    tests_run++;
    if ({wb_ack_o, wb_err_o, irq_o, o_dbg_state} !== 4'b0000 || wb_dat_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ack=%b err=%b irq=%b state=%b dat=%h, required all 0",
               wb_ack_o, wb_err_o, irq_o, o_dbg_state, wb_dat_o);
    end
    do_access(32'h18, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
    tests_run++;
    if (ack !== 1'b1 || rd !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: ack=%b data=%h, required ack=1 data=0", ack, rd);
    end
    m_cnt = 32'd1;
  endtask

  task automatic test_id_regs();
    logic ack, err, early;
    logic [31:0] rd;
    logic [31:0] adrs [3];
    logic [31:0] exps [3];
    adrs = '{32'h00, 32'h04, 32'h08};
    exps = '{32'd5, 32'd4, 32'd20};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_access(adrs[i], 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
      tests_run++;
      if (early !== 1'b0 || ack !== 1'b1 || err !== 1'b0 || rd !== exps[i]) begin
        tests_failed++;
        $display("FAIL id_reg_%0d: early=%b ack=%b err=%b data=%0d, required early=0 ack=1 err=0 data=%0d",
                 i, early, ack, err, rd, exps[i]);
      end
    end
    do_access(32'h18, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
    tests_run++;
    if (ack !== 1'b1 || rd !== 32'd3) begin
      tests_failed++;
      $display("FAIL access_cnt_after_3: ack=%b data=%0d, required ack=1 data=3", ack, rd);
    end
    m_cnt = 32'd4;
  endtask

  task automatic test_scratch();
    logic ack, err, early, e_err;
    logic [31:0] rd, e_rd, cnt_before;
    model_op(32'h0C, 32'hAABBCCDD, 4'b0101, 1'b1, 2'b00, e_err, e_rd);
    do_access(32'h0C, 32'hAABBCCDD, 4'b0101, 1'b1, 2'b00, ack, err, rd, early);
    model_op(32'h0C, 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
    do_access(32'h0C, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
    tests_run++;
    if (ack !== 1'b1 || rd !== 32'h00BB00DD) begin
      tests_failed++;
      $display("FAIL scratch_sel: ack=%b data=%h, required ack=1 data=00bb00dd", ack, rd);
    end
    cnt_before = m_cnt;
    model_op(32'h00, 32'h1234, 4'hF, 1'b1, 2'b00, e_err, e_rd);
    do_access(32'h00, 32'h1234, 4'hF, 1'b1, 2'b00, ack, err, rd, early);
    tests_run++;
    if (ack !== 1'b0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ro_write_err: ack=%b err=%b, required ack=0 err=1", ack, err);
    end
    model_op(32'h18, 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
    do_access(32'h18, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
    tests_run++;
    if (rd !== cnt_before) begin
      tests_failed++;
      $display("FAIL cnt_after_err: data=%0d, required %0d", rd, cnt_before);
    end
  endtask

  task automatic test_irq();
    logic ack, err, early, e_err;
    logic [31:0] rd, e_rd;
    model_op(32'h14, 32'h3, 4'hF, 1'b1, 2'b00, e_err, e_rd);
    do_access(32'h14, 32'h3, 4'hF, 1'b1, 2'b00, ack, err, rd, early);
    @(posedge clk); #1 irq_src_i = 2'b10;
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_before_set: irq=%b, required 0", irq_o);
    end
    @(posedge clk); #1 irq_src_i = 2'b00;
    m_status = m_status | 2'b10;
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_after_set: irq=%b, required 1", irq_o);
    end
    model_op(32'h10, 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
    do_access(32'h10, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
    tests_run++;
    if (rd !== 32'h2) begin
      tests_failed++;
      $display("FAIL status_set: data=%h, required 2", rd);
    end
    model_op(32'h10, 32'h2, 4'hF, 1'b1, 2'b10, e_err, e_rd);
    do_access(32'h10, 32'h2, 4'hF, 1'b1, 2'b10, ack, err, rd, early);
    model_op(32'h10, 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
    do_access(32'h10, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
    tests_run++;
    if (rd !== {30'd0, m_status} || irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_beats_clear: status=%h irq=%b, required status=2 irq=1", rd, irq_o);
    end
    model_op(32'h10, 32'h3, 4'hF, 1'b1, 2'b00, e_err, e_rd);
    do_access(32'h10, 32'h3, 4'hF, 1'b1, 2'b00, ack, err, rd, early);
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_after_w1c: irq=%b, required 0", irq_o);
    end
  endtask

  task automatic test_err_and_drop();
    logic ack, err, early, e_err;
    logic [31:0] rd, e_rd;
    logic [31:0] adrs [3];
    adrs = '{32'h03, 32'h40, 32'h1C};
    for (int i = 0; i < 3; i++) begin
`ifdef NOC_CONF_TIMESTAMP_EN
      if (i == 2) break;
`endif
      model_op(adrs[i], 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
      do_access(adrs[i], 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
      tests_run++;
      if (ack !== 1'b0 || err !== 1'b1 || rd !== 32'd0) begin
        tests_failed++;
        $display("FAIL bad_read_%h: ack=%b err=%b data=%h, required ack=0 err=1 data=0",
                 adrs[i], ack, err, rd);
      end
    end
    @(posedge clk); #1;
    wb_adr_i = 32'h0C; wb_dat_i = 32'hDEADBEEF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_stb_i = 1'b0;
    #1;
    tests_run++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_stb: ack=%b err=%b, required 0 0", wb_ack_o, wb_err_o);
    end
    @(posedge clk); #1 wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    model_op(32'h0C, 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
    do_access(32'h0C, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
    tests_run++;
    if (rd !== e_rd) begin
      tests_failed++;
      $display("FAIL drop_no_write: scratch=%h, required %h", rd, e_rd);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic prev, cur;
    acks = 0; prev = 1'b0;
    @(posedge clk); #1;
    wb_adr_i = 32'h0C; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 cur = wb_ack_o;
      tests_run++;
      if (cur !== (i % 2 == 1) || (cur && wb_dat_o !== m_scratch) || (cur && prev)) begin
        tests_failed++;
        $display("FAIL b2b_cycle_%0d: ack=%b data=%h, required ack=%0d data=%h",
                 i, cur, wb_dat_o, (i % 2 == 1), m_scratch);
      end
      if (cur === 1'b1) acks++;
      prev = cur;
      @(posedge clk); #1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    m_cnt = m_cnt + 32'd3;
    tests_run++;
    if (acks != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: acks=%0d, required 3", acks);
    end
  endtask

  task automatic test_reset_mid();
    logic ack, err, early, e_err;
    logic [31:0] rd, e_rd;
    logic [31:0] adrs [4];
    model_op(32'h0C, 32'h5555AAAA, 4'hF, 1'b1, 2'b00, e_err, e_rd);
    do_access(32'h0C, 32'h5555AAAA, 4'hF, 1'b1, 2'b00, ack, err, rd, early);
    model_op(32'h14, 32'h1, 4'hF, 1'b1, 2'b01, e_err, e_rd);
    do_access(32'h14, 32'h1, 4'hF, 1'b1, 2'b01, ack, err, rd, early);
    @(posedge clk); #1;
    wb_adr_i = 32'h0C; wb_dat_i = 32'h12345678; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || irq_o !== 1'b0 || o_dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_abort: ack=%b err=%b irq=%b state=%b, required all 0",
               wb_ack_o, wb_err_o, irq_o, o_dbg_state);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    adrs = '{32'h18, 32'h0C, 32'h10, 32'h14};
    for (int i = 0; i < 4; i++) begin
      model_op(adrs[i], 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
      do_access(adrs[i], 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd, early);
      tests_run++;
      if (ack !== 1'b1 || rd !== e_rd) begin
        tests_failed++;
        $display("FAIL reset_mid_reg_%h: ack=%b data=%h, required ack=1 data=%h",
                 adrs[i], ack, rd, e_rd);
      end
    end
  endtask

  task automatic test_random();
    logic ack, err, early, e_err, we;
    logic [31:0] rd, e_rd, adr, dat;
    logic [3:0] sel;
    logic [1:0] src;
    int k;
    for (int n = 0; n < 300; n++) begin
      k   = $urandom_range(0, 9);
      we  = 1'($urandom_range(0, 1));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (k < 8)       adr = 32'(k * 4);
      else if (k == 8) adr = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else             adr = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0020;
`ifdef NOC_CONF_TIMESTAMP_EN
      if (adr == 32'h1C) we = 1'b1;
`endif
      model_op(adr, dat, sel, we, src, e_err, e_rd);
      do_access(adr, dat, sel, we, src, ack, err, rd, early);
      tests_run++;
      if (early !== 1'b0 || err !== e_err || ack !== !e_err ||
          ((!we || e_err) && rd !== (e_err ? 32'd0 : e_rd)) ||
          irq_o !== |(m_status & m_mask)) begin
        tests_failed++;
        $display("FAIL random_%0d adr=%h we=%b: early=%b ack=%b err=%b data=%h irq=%b, required err=%b data=%h irq=%b",
                 n, adr, we, early, ack, err, rd, irq_o, e_err, e_rd, |(m_status & m_mask));
      end
    end
  endtask

  task automatic test_timestamp();
    logic ack, err, early, e_err;
    logic [31:0] rd1, rd2, e_rd;
`ifdef NOC_CONF_TIMESTAMP_EN
    do_access(32'h1C, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd1, early);
    repeat (7) @(posedge clk);
    do_access(32'h1C, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd2, early);
    m_cnt = m_cnt + 32'd2;
    tests_run++;
    if (ack !== 1'b1 || rd2 - rd1 !== 32'd10) begin
      tests_failed++;
      $display("FAIL timestamp_delta: ack=%b delta=%0d, required ack=1 delta=10", ack, rd2 - rd1);
    end
`else
    rd2 = 32'd0;
    model_op(32'h1C, 32'd0, 4'hF, 1'b0, 2'b00, e_err, e_rd);
    do_access(32'h1C, 32'd0, 4'hF, 1'b0, 2'b00, ack, err, rd1, early);
    tests_run++;
    if (ack !== 1'b0 || err !== 1'b1 || rd1 !== rd2) begin
      tests_failed++;
      $display("FAIL timestamp_disabled: ack=%b err=%b data=%h, required ack=0 err=1 data=0",
               ack, err, rd1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_scratch();
    test_irq();
    test_err_and_drop();
    test_back_to_back();
    test_reset_mid();
    test_timestamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
